// File: rtl/prom_block_averager.sv
`default_nettype none
// ============================================================================
//  Module   : prom_block_averager
//  Purpose  : Block-averaging stage in front of the averaged-sample FIFO.
//             Accumulates 2^L consecutive signed samples and emits one
//             floor-rounded mean per block on a 32-bit Avalon-ST source.
//             Runs are started and stopped by processor control pulses.
//             There is no backpressure input.
//
//  Ports    :
//    clk                    in   1       single clock
//    reset_n                in   1       synchronous, active-low reset
//    start                  in   1       pulse, begins a run (ignored if busy)
//    stop                   in   1       pulse, aborts a run (ignored in IDLE)
//    log2_n                 in   5       block length exponent, clamped to 16
//    num_results            in   16      results per run, 0 = continuous
//    data_in                in   DATA_W  signed input sample
//    data_in_valid          in   1       qualifies data_in
//    avalonst_source_data   out  32      block mean, sign-extended
//    avalonst_source_valid  out  1       one-cycle pulse per result
//    busy                   out  1       high while a run is active
//    done                   out  1       pulse when a finite run completes
//
//  Revision : 1.0  initial release
// ============================================================================
module prom_block_averager #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = DATA_W + 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic [4:0]               log2_n,
    input  logic [15:0]              num_results,
    input  logic signed [DATA_W-1:0] data_in,
    input  logic                     data_in_valid,
    output logic [31:0]              avalonst_source_data,
    output logic                     avalonst_source_valid,
    output logic                     busy,
    output logic                     done
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [4:0] C_MAX_LOG2 = 5'd16;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]              r_state;
    logic [4:0]              r_log2;      // latched, already clamped
    logic [15:0]             r_num;       // latched result count, 0 = endless
    logic [15:0]             r_cnt;       // sample index within block
    logic [15:0]             r_res_cnt;   // results emitted in this run
    logic signed [ACC_W-1:0] r_acc;
    logic [31:0]             r_out_data;
    logic                    r_out_valid;

    // ------------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------------
    logic [4:0]              w_log2_clamped;
    logic [15:0]             w_mask;
    logic                    w_first;
    logic                    w_last;
    logic                    w_final;
    logic signed [ACC_W-1:0] w_sample_ext;
    logic signed [ACC_W-1:0] w_acc_next;
    logic signed [ACC_W-1:0] w_mean;
    logic [31:0]             w_mean32;

    assign w_log2_clamped = (log2_n > C_MAX_LOG2) ? C_MAX_LOG2 : log2_n;

    // 2^L - 1 built by shifting down an all-ones word; L=0 gives 0 so every
    // sample is both first and last (pass-through).
    assign w_mask  = 16'hFFFF >> (C_MAX_LOG2 - r_log2);
    assign w_first = (r_cnt == 16'd0);
    assign w_last  = (r_cnt == w_mask);

    assign w_sample_ext = ACC_W'(data_in);

    // First sample of a block reloads the accumulator instead of adding,
    // so blocks follow each other without a clearing bubble.
    assign w_acc_next = w_first ? w_sample_ext : (r_acc + w_sample_ext);

    // Arithmetic shift floors toward -inf, which is the required rounding.
    assign w_mean = w_acc_next >>> r_log2;

    // The mean always fits in DATA_W bits, so narrowing to 32 bits when
    // ACC_W exceeds 32 drops only redundant sign bits.
    generate
        if (ACC_W >= 32) begin : g_mean_trunc
            assign w_mean32 = w_mean[31:0];
            if (ACC_W > 32) begin : g_mean_hi
                logic w_unused_hi;
                assign w_unused_hi = ^w_mean[ACC_W-1:32];
            end
        end else begin : g_mean_sext
            assign w_mean32 = {{(32-ACC_W){w_mean[ACC_W-1]}}, w_mean};
        end
    endgenerate

    // The result about to be emitted is the last one of a finite run.
    assign w_final = (r_num != 16'd0) && (r_res_cnt == (r_num - 16'd1));

    // ------------------------------------------------------------------------
    // Control and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_log2      <= 5'd0;
            r_num       <= 16'd0;
            r_cnt       <= 16'd0;
            r_res_cnt   <= 16'd0;
            r_acc       <= '0;
            r_out_data  <= 32'd0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // stop has no meaning here, so start always wins
                    if (start) begin
                        r_state   <= S_RUN;
                        r_log2    <= w_log2_clamped;
                        r_num     <= num_results;
                        r_cnt     <= 16'd0;
                        r_res_cnt <= 16'd0;
                        r_acc     <= '0;
                    end
                end
                S_RUN: begin
                    // stop outranks a block-completing sample: the partial
                    // or just-finished block is simply dropped.
                    if (stop) begin
                        r_state <= S_IDLE;
                    end else if (data_in_valid) begin
                        r_acc <= w_acc_next;
                        if (w_last) begin
                            r_cnt       <= 16'd0;
                            r_out_data  <= w_mean32;
                            r_out_valid <= 1'b1;
                            r_res_cnt   <= r_res_cnt + 16'd1;
                            if (w_final) begin
                                r_state <= S_DONE;
                            end
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign avalonst_source_data  = r_out_data;
    assign avalonst_source_valid = r_out_valid;
    assign busy                  = (r_state != S_IDLE);
    // DONE lasts exactly the cycle in which the final result is presented.
    assign done                  = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: doc/prom_block_averager.md
# prom_block_averager

Block-averaging stage that feeds the averaged-sample FIFO read by the processor. It accumulates 2^log2_n consecutive signed input samples and emits one arithmetic-mean word per block on a 32-bit Avalon-ST source. Runs are started and stopped by control bits from the processor. It has no backpressure input; the downstream FIFO absorbs output or drops it on overflow.

## Interface
Parameters:
- DATA_W, 16, signed input sample width; legal range 2..32.
- ACC_W, DATA_W+16, accumulator width; sized so that 2^16 full-scale samples cannot overflow.

Ports:
- clk  in  1  single clock for the whole block.
- reset_n  in  1  reset, synchronous, active-low.
- start  in  1  single-cycle pulse; begins a run; ignored while busy.
- stop  in  1  single-cycle pulse; aborts a run; ignored in IDLE.
- log2_n  in  5  log2 of the block length; latched at start; values >16 are clamped to 16.
- num_results  in  16  number of output words per run, latched at start; 0 means continuous until stop.
- data_in  in  DATA_W  signed input sample.
- data_in_valid  in  1  qualifies data_in for one cycle.
- avalonst_source_data  out  32  block mean, sign-extended to 32 bits.
- avalonst_source_valid  out  1  one-cycle pulse per result.
- busy  out  1  high while a run is active.
- done  out  1  one-cycle pulse when a finite run completes.

## Operation
- State machine with states IDLE, RUN and DONE.
- IDLE -> RUN: on start.
  - On this transition, latch the clamped log2_n (L) and num_results (R).
  - Clear the sample counter, the result counter and the accumulator.
- RUN behaviour on each data_in_valid:
  - acc_next = (cnt==0 ? sext(data_in) : acc + sext(data_in)).
  - cnt increments modulo 2^L.
- Last sample of a block is the valid sample taken when cnt==2^L-1. On that sample:
  - Register avalonst_source_data = sext32(acc_next >>> L), an arithmetic shift that floors toward -inf.
  - Pulse avalonst_source_valid.
  - Increment the result counter.
  - The next block starts fresh because cnt wraps to 0.
- RUN -> DONE: when R!=0 and the result just emitted is the R-th.
- DONE -> IDLE: unconditionally after one cycle.
- RUN -> IDLE: on stop.
  - The partial block is discarded.
  - No valid or done is produced for it.
- L=0 is pass-through: every valid sample produces one output equal to the sample.
- Simultaneous events:
  - start and stop in the same IDLE cycle: start wins.
  - stop on the same cycle as a block-completing sample: stop wins. That result is discarded and done is not asserted.
  - start while in RUN or DONE: ignored.
- Inputs log2_n and num_results may change freely during a run. Only the values latched at start are used.

## Timing
- Reset values: avalonst_source_data=0, avalonst_source_valid=0, busy=0, done=0. The state machine goes to IDLE and all counters and the accumulator are cleared.
- A reset asserted mid-run takes effect on the next edge. No result or done is emitted for the interrupted run.
- busy rises on the edge that samples start, i.e. in the first RUN cycle.
- Output latency: avalonst_source_valid is high in the cycle after the clock edge that samples the last valid input of the block. That is 1 cycle of latency.
- valid is never high for more than one consecutive cycle, except when L=0 with back-to-back input valids.
- done is high in the same cycle as the final avalonst_source_valid, i.e. while in DONE.
  - busy is still high in that cycle.
  - busy falls on the next edge.
- The earliest a new start is accepted is the first IDLE cycle after DONE.
- Gaps in data_in_valid are allowed; non-valid cycles leave acc and cnt unchanged.
- Throughput is one sample per cycle with no bubbles between blocks.

## Test plan
- Basic mean: L=2, R=1, samples 1,2,3,4 back-to-back.
  - Single valid with data 0x00000002, one cycle after sample 4.
  - done in that same cycle; busy drops next cycle.
- Negative floor: L=2, R=1, samples -1,-2,-3,-4.
  - Data 0xFFFFFFFD (-3, the floor of -2.5).
- Full-scale, no overflow: L=16, R=2, 131072 samples of +32767 with random valid gaps.
  - Two outputs of 0x00007FFF; done with the second.
- Pass-through and continuous: L=0, R=0, samples 5,-7,9.
  - Outputs 5, 0xFFFFFFF9, 9, each one cycle after its input.
  - Run continues until a stop pulse; done is never asserted.
- Abort and priority:
  - L=3, R=4: stop after 5 samples gives no output and busy=0 on the next cycle.
  - Stop coincident with the 8th sample gives no valid.
  - A start in the same cycle as stop while in IDLE begins a run.
- Reset mid-run: L=2, R=3, reset_n low after 6 samples.
  - All outputs are 0 on the next edge; no valid or done follows.
  - A new start after release produces a correct first result from fresh samples.
